acceso_memoria: RTL and testbench

- Initiator side of the data-memory interface: the MEM-stage load/store unit that drives EscrMem, LeerMem, Direc and Datain, and consumes Dataout.
- Accepts one load or store request at a time from the pipeline and raises busy while the request is in progress.
- Performs byte/halfword/word accesses with sign or zero extension. Sub-word stores use read-modify-write.
- Detects region, ROM-write, misalignment and size faults before any memory access.

---
 rtl/acceso_memoria.sv | 224 ++++++++++++++++++++++
 tb/tb_acceso_memoria.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/acceso_memoria.sv
// MEM-stage load/store unit: drives the data-memory strobes and formats loads.
// Sub-word stores are done as read-modify-write; faulting requests never touch memory.
module acceso_memoria #(
    parameter int RAM_PAGES = 4,
    parameter int ROM_PAGE  = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_store,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        busy,
    output logic        done,
    output logic        fault,
    output logic [31:0] load_data,
    output logic        EscrMem,
    output logic        LeerMem,
    output logic [31:0] Direc,
    output logic [31:0] Datain,
    input  logic [31:0] Dataout
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACCESS,
        S_WAIT,
        S_MERGE,
        S_DONE,
        S_FAULT
    } state_t;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;
    localparam logic [1:0] SIZE_BAD  = 2'b11;

    state_t      state_q;
    logic        store_q;
    logic [1:0]  size_q;
    logic        signed_q;
    logic [1:0]  offset_q;
    logic [15:0] wdata_q;
    logic        busy_q;
    logic        done_q;
    logic        fault_q;
    logic [31:0] loadData_q;
    logic        escr_q;
    logic        leer_q;
    logic [31:0] direc_q;
    logic [31:0] datain_q;

    // A request is rejected on size, alignment, unmapped page, or a write to ROM.
    function automatic logic checkFault(input logic        isStore,
                                        input logic [1:0]  size,
                                        input logic [31:0] addr);
        logic [23:0] page;
        logic        inRam;
        logic        inRom;
        logic        isBad;
        page  = addr[31:8];
        inRam = page < 24'(RAM_PAGES);
        inRom = page == 24'(ROM_PAGE);
        isBad = 1'b0;
        if (size == SIZE_BAD)
            isBad = 1'b1;
        if (size == SIZE_HALF && addr[0])
            isBad = 1'b1;
        if (size == SIZE_WORD && addr[1:0] != 2'b00)
            isBad = 1'b1;
        if (!(inRam || inRom))
            isBad = 1'b1;
        if (isStore && inRom)
            isBad = 1'b1;
        return isBad;
    endfunction

    function automatic logic [31:0] extendLoad(input logic [31:0] word,
                                               input logic [1:0]  offset,
                                               input logic [1:0]  size,
                                               input logic        sgn);
        logic [31:0] lane;
        logic [31:0] result;
        lane = word >> {offset, 3'b000};
        case (size)
            SIZE_BYTE: result = {{24{sgn & lane[7]}}, lane[7:0]};
            SIZE_HALF: result = {{16{sgn & lane[15]}}, lane[15:0]};
            default:   result = word;
        endcase
        return result;
    endfunction

    // Replace only the addressed lane(s) of the word just read back.
    function automatic logic [31:0] mergeStore(input logic [31:0] word,
                                               input logic [1:0]  offset,
                                               input logic [1:0]  size,
                                               input logic [15:0] wdata);
        logic [31:0] mask;
        logic [31:0] ins;
        if (size == SIZE_BYTE) begin
            mask = 32'h0000_00FF << {offset, 3'b000};
            ins  = {24'h0, wdata[7:0]} << {offset, 3'b000};
        end else begin
            mask = 32'h0000_FFFF << {offset, 3'b000};
            ins  = {16'h0, wdata} << {offset, 3'b000};
        end
        return (word & ~mask) | ins;
    endfunction

    // Outputs are registered alongside the state they belong to, so each
    // transition loads the values the destination state presents.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            store_q    <= 1'b0;
            size_q     <= 2'b00;
            signed_q   <= 1'b0;
            offset_q   <= 2'b00;
            wdata_q    <= 16'h0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            fault_q    <= 1'b0;
            loadData_q <= 32'h0;
            escr_q     <= 1'b0;
            leer_q     <= 1'b0;
            direc_q    <= 32'h0;
            datain_q   <= 32'h0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req_valid) begin
                        store_q  <= req_store;
                        size_q   <= req_size;
                        signed_q <= req_signed;
                        offset_q <= req_addr[1:0];
                        wdata_q  <= req_wdata[15:0];
                        busy_q   <= 1'b1;
                        if (checkFault(req_store, req_size, req_addr)) begin
                            state_q <= S_FAULT;
                            done_q  <= 1'b1;
                            fault_q <= 1'b1;
                        end else begin
                            state_q <= S_ACCESS;
                            direc_q <= {req_addr[31:2], 2'b00};
                            if (req_store && req_size == SIZE_WORD) begin
                                escr_q   <= 1'b1;
                                datain_q <= req_wdata;
                            end else begin
                                leer_q <= 1'b1;
                            end
                        end
                    end
                end

                S_ACCESS: begin
                    if (store_q && size_q == SIZE_WORD) begin
                        state_q  <= S_DONE;
                        escr_q   <= 1'b0;
                        datain_q <= 32'h0;
                        direc_q  <= 32'h0;
                        done_q   <= 1'b1;
                    end else begin
                        state_q <= S_WAIT;
                    end
                end

                // Dataout now holds the word addressed in ACCESS.
                S_WAIT: begin
                    leer_q <= 1'b0;
                    if (store_q) begin
                        state_q  <= S_MERGE;
                        escr_q   <= 1'b1;
                        datain_q <= mergeStore(Dataout, offset_q, size_q, wdata_q);
                    end else begin
                        state_q    <= S_DONE;
                        direc_q    <= 32'h0;
                        done_q     <= 1'b1;
                        loadData_q <= extendLoad(Dataout, offset_q, size_q, signed_q);
                    end
                end

                S_MERGE: begin
                    state_q  <= S_DONE;
                    escr_q   <= 1'b0;
                    datain_q <= 32'h0;
                    direc_q  <= 32'h0;
                    done_q   <= 1'b1;
                end

                S_DONE, S_FAULT: begin
                    state_q    <= S_IDLE;
                    busy_q     <= 1'b0;
                    done_q     <= 1'b0;
                    fault_q    <= 1'b0;
                    loadData_q <= 32'h0;
                end

                default: begin
                    state_q    <= S_IDLE;
                    busy_q     <= 1'b0;
                    done_q     <= 1'b0;
                    fault_q    <= 1'b0;
                    loadData_q <= 32'h0;
                    escr_q     <= 1'b0;
                    leer_q     <= 1'b0;
                    direc_q    <= 32'h0;
                    datain_q   <= 32'h0;
                end
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign fault     = fault_q;
    assign load_data = loadData_q;
    assign EscrMem   = escr_q;
    assign LeerMem   = leer_q;
    assign Direc     = direc_q;
    assign Datain    = datain_q;

endmodule

// File: tb/tb_acceso_memoria.sv
// Directed bench for acceso_memoria with a one-cycle-latency word memory model.
// Each scenario task drives a request and compares against hand-computed values.
module tb_acceso_memoria;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_store;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        busy;
    logic        done;
    logic        fault;
    logic [31:0] load_data;
    logic        EscrMem;
    logic        LeerMem;
    logic [31:0] Direc;
    logic [31:0] Datain;
    logic [31:0] Dataout;

    int total = 0;
    int bad   = 0;

    logic [31:0] mem [0:1023];
    logic        tbWr = 1'b0;
    logic [9:0]  tbWrIdx = '0;
    logic [31:0] tbWrData = '0;
    int          bothStrobes = 0;
    int          idleDirty = 0;

    int          rDone;
    logic        rFault;
    logic [31:0] rData;
    int          rRd;
    int          rWr;
    int          rWrCyc;
    logic [31:0] rWrAddr;
    logic [31:0] rWrData;

    always #5 clk = ~clk;

    acceso_memoria #(.RAM_PAGES(4), .ROM_PAGE(4)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_store(req_store),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata), .busy(busy), .done(done), .fault(fault),
        .load_data(load_data), .EscrMem(EscrMem), .LeerMem(LeerMem),
        .Direc(Direc), .Datain(Datain), .Dataout(Dataout)
    );

    // Memory answers a read one cycle after LeerMem/Direc are presented.
    always @(posedge clk) begin
        if (LeerMem) Dataout <= mem[Direc[11:2]];
        if (EscrMem) mem[Direc[11:2]] <= Datain;
        if (tbWr) mem[tbWrIdx] <= tbWrData;
    end

    always @(negedge clk) begin
        if (EscrMem && LeerMem) bothStrobes++;
        if (!busy && (Direc != 32'h0 || Datain != 32'h0)) idleDirty++;
    end

    task automatic preload(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        tbWr = 1'b1; tbWrIdx = a[11:2]; tbWrData = d;
        @(negedge clk);
        tbWr = 1'b0;
    endtask

    // Issues one request and records strobe/done timing relative to the accepting edge.
    task automatic applyStimulus(input logic st, input logic [1:0] sz, input logic sg,
                                 input logic [31:0] a, input logic [31:0] wd);
        @(negedge clk);
        req_store = st; req_size = sz; req_signed = sg; req_addr = a; req_wdata = wd;
        req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        rDone = 0; rFault = 1'b0; rData = 32'h0; rRd = 0; rWr = 0; rWrCyc = 0;
        rWrAddr = 32'h0; rWrData = 32'h0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (LeerMem) rRd++;
            if (EscrMem) begin
                rWr++; rWrCyc = k; rWrAddr = Direc; rWrData = Datain;
            end
            if (done) begin
                rDone = k; rFault = fault; rData = load_data;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; req_valid = 1'b1; req_store = 1'b0; req_size = 2'b10;
        req_signed = 1'b0; req_addr = 32'h104; req_wdata = 32'h0;
        repeat (3) @(negedge clk);
        total++;
        if ({busy, done, fault, EscrMem, LeerMem} !== 5'b0) begin
            bad++; $display("[TB] FAIL reset_ctrl: got %b expected 00000", {busy, done, fault, EscrMem, LeerMem});
        end
        total++;
        if (Direc !== 32'h0) begin bad++; $display("[TB] FAIL reset_direc: got %h expected 0", Direc); end
        total++;
        if (Datain !== 32'h0) begin bad++; $display("[TB] FAIL reset_datain: got %h expected 0", Datain); end
        total++;
        if (load_data !== 32'h0) begin bad++; $display("[TB] FAIL reset_load_data: got %h expected 0", load_data); end
        reset = 1'b0; req_valid = 1'b0;
    endtask

    task automatic test_word_store();
        applyStimulus(1'b1, 2'b10, 1'b0, 32'h104, 32'hDEADBEEF);
        total++;
        if (rWrCyc !== 1 || rWr !== 1) begin bad++; $display("[TB] FAIL wst_escr_cycle: got %0d/%0d expected 1/1", rWrCyc, rWr); end
        total++;
        if (rWrAddr !== 32'h104) begin bad++; $display("[TB] FAIL wst_direc: got %h expected 00000104", rWrAddr); end
        total++;
        if (rWrData !== 32'hDEADBEEF) begin bad++; $display("[TB] FAIL wst_datain: got %h expected deadbeef", rWrData); end
        total++;
        if (rDone !== 2 || rFault !== 1'b0 || rRd !== 0) begin
            bad++; $display("[TB] FAIL wst_done: got cyc=%0d fault=%b rd=%0d expected 2 0 0", rDone, rFault, rRd);
        end
        applyStimulus(1'b0, 2'b10, 1'b0, 32'h104, 32'h0);
        total++;
        if (rDone !== 3 || rRd !== 2 || rWr !== 0) begin
            bad++; $display("[TB] FAIL wld_timing: got done=%0d rd=%0d wr=%0d expected 3 2 0", rDone, rRd, rWr);
        end
        total++;
        if (rData !== 32'hDEADBEEF) begin bad++; $display("[TB] FAIL wld_data: got %h expected deadbeef", rData); end
    endtask

    task automatic test_subword_store();
        preload(32'h200, 32'h11223344);
        applyStimulus(1'b1, 2'b00, 1'b0, 32'h202, 32'h000000AA);
        total++;
        if (rRd !== 2 || rWrCyc !== 3 || rDone !== 4) begin
            bad++; $display("[TB] FAIL bst_timing: got rd=%0d wr=%0d done=%0d expected 2 3 4", rRd, rWrCyc, rDone);
        end
        total++;
        if (rWrData !== 32'h11AA3344 || rWrAddr !== 32'h200) begin
            bad++; $display("[TB] FAIL bst_merge: got %h@%h expected 11aa3344@00000200", rWrData, rWrAddr);
        end
        applyStimulus(1'b1, 2'b01, 1'b0, 32'h202, 32'h1234BEEF);
        total++;
        if (rWrData !== 32'hBEEF3344 || rDone !== 4 || rFault !== 1'b0) begin
            bad++; $display("[TB] FAIL hst_merge: got %h done=%0d expected beef3344 4", rWrData, rDone);
        end
        total++;
        if (mem[32'h200 >> 2] !== 32'hBEEF3344) begin
            bad++; $display("[TB] FAIL hst_memory: got %h expected beef3344", mem[32'h200 >> 2]);
        end
    endtask

    task automatic test_loads();
        preload(32'h200, 32'h80FF7F01);
        applyStimulus(1'b0, 2'b00, 1'b1, 32'h203, 32'h0);
        total++;
        if (rData !== 32'hFFFFFF80 || rDone !== 3) begin bad++; $display("[TB] FAIL ld_sbyte: got %h expected ffffff80", rData); end
        applyStimulus(1'b0, 2'b01, 1'b0, 32'h202, 32'h0);
        total++;
        if (rData !== 32'h000080FF) begin bad++; $display("[TB] FAIL ld_uhalf: got %h expected 000080ff", rData); end
        applyStimulus(1'b0, 2'b01, 1'b1, 32'h200, 32'h0);
        total++;
        if (rData !== 32'h00007F01) begin bad++; $display("[TB] FAIL ld_shalf_pos: got %h expected 00007f01", rData); end
        applyStimulus(1'b0, 2'b01, 1'b1, 32'h202, 32'h0);
        total++;
        if (rData !== 32'hFFFF80FF) begin bad++; $display("[TB] FAIL ld_shalf_neg: got %h expected ffff80ff", rData); end
        applyStimulus(1'b0, 2'b00, 1'b0, 32'h202, 32'h0);
        total++;
        if (rData !== 32'h000000FF) begin bad++; $display("[TB] FAIL ld_ubyte: got %h expected 000000ff", rData); end
    endtask

    task automatic test_faults();
        logic        st [5];
        logic [1:0]  sz [5];
        logic [31:0] ad [5];
        st[0] = 1'b0; sz[0] = 2'b10; ad[0] = 32'h102;
        st[1] = 1'b0; sz[1] = 2'b01; ad[1] = 32'h001;
        st[2] = 1'b0; sz[2] = 2'b11; ad[2] = 32'h100;
        st[3] = 1'b1; sz[3] = 2'b10; ad[3] = 32'h400;
        st[4] = 1'b0; sz[4] = 2'b10; ad[4] = 32'h500;
        for (int i = 0; i < 5; i++) begin
            applyStimulus(st[i], sz[i], 1'b0, ad[i], 32'h5A5A5A5A);
            total++;
            if (rDone !== 1 || rFault !== 1'b1 || rRd !== 0 || rWr !== 0 || rData !== 32'h0) begin
                bad++;
                $display("[TB] FAIL fault_%0d: got done=%0d fault=%b rd=%0d wr=%0d data=%h expected 1 1 0 0 0",
                         i, rDone, rFault, rRd, rWr, rData);
            end
        end
    endtask

    task automatic test_rom_load();
        preload(32'h400, 32'hCAFEF00D);
        applyStimulus(1'b0, 2'b10, 1'b0, 32'h400, 32'h0);
        total++;
        if (rFault !== 1'b0 || rDone !== 3 || rData !== 32'hCAFEF00D) begin
            bad++; $display("[TB] FAIL rom_load: got fault=%b done=%0d data=%h expected 0 3 cafef00d", rFault, rDone, rData);
        end
    endtask

    task automatic test_reset_mid();
        int escrSeen;
        int doneSeen;
        preload(32'h300, 32'h55667788);
        @(negedge clk);
        req_store = 1'b1; req_size = 2'b00; req_signed = 1'b0; req_addr = 32'h301;
        req_wdata = 32'h99; req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if (LeerMem !== 1'b1) begin bad++; $display("[TB] FAIL rst_mid_wait: got LeerMem=%b expected 1", LeerMem); end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        total++;
        if (busy !== 1'b0) begin bad++; $display("[TB] FAIL rst_mid_busy: got %b expected 0", busy); end
        escrSeen = EscrMem ? 1 : 0;
        doneSeen = done ? 1 : 0;
        repeat (6) begin
            @(negedge clk);
            if (EscrMem) escrSeen++;
            if (done) doneSeen++;
        end
        total++;
        if (escrSeen !== 0 || doneSeen !== 0) begin
            bad++; $display("[TB] FAIL rst_mid_quiet: got escr=%0d done=%0d expected 0 0", escrSeen, doneSeen);
        end
        total++;
        if (mem[32'h300 >> 2] !== 32'h55667788) begin
            bad++; $display("[TB] FAIL rst_mid_memory: got %h expected 55667788", mem[32'h300 >> 2]);
        end
    endtask

    task automatic test_back_to_back();
        int          dones [2];
        logic [31:0] datas [2];
        int          nDone;
        int          busyLow;
        int          strobeIdle;
        nDone = 0; busyLow = 0; strobeIdle = 0;
        dones[0] = 0; dones[1] = 0; datas[0] = 32'h0; datas[1] = 32'h0;
        @(negedge clk);
        req_store = 1'b0; req_size = 2'b10; req_signed = 1'b0; req_addr = 32'h104;
        req_valid = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (!busy) busyLow = k;
            if ((LeerMem || EscrMem) && !busy) strobeIdle++;
            if (done) begin
                dones[nDone] = k; datas[nDone] = load_data; nDone++;
                req_addr = 32'h200;
                if (nDone == 2) break;
            end
        end
        req_valid = 1'b0;
        total++;
        if (dones[0] !== 3 || dones[1] !== 7) begin
            bad++; $display("[TB] FAIL b2b_done: got %0d,%0d expected 3,7", dones[0], dones[1]);
        end
        total++;
        if (busyLow !== 4 || strobeIdle !== 0) begin
            bad++; $display("[TB] FAIL b2b_busy: got idle_cycle=%0d strobe_idle=%0d expected 4 0", busyLow, strobeIdle);
        end
        total++;
        if (datas[0] !== 32'hDEADBEEF || datas[1] !== 32'h80FF7F01) begin
            bad++; $display("[TB] FAIL b2b_data: got %h,%h expected deadbeef,80ff7f01", datas[0], datas[1]);
        end
    endtask

    initial begin
        Dataout = 32'h0;
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
        test_reset();
        test_word_store();
        test_subword_store();
        test_loads();
        test_faults();
        test_rom_load();
        test_reset_mid();
        test_back_to_back();
        total++;
        if (bothStrobes !== 0) begin bad++; $display("[TB] FAIL strobe_exclusive: got %0d expected 0", bothStrobes); end
        total++;
        if (idleDirty !== 0) begin bad++; $display("[TB] FAIL idle_bus_zero: got %0d expected 0", idleDirty); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
